// File: rtl/ntt_if.sv
// ntt_if: coefficient stream in, transform stream out, plus the busy flag
interface ntt_if #(parameter int BITS = 32);
  logic            in_valid, in_ready, out_valid, out_ready, out_last, busy;
  logic [BITS-1:0] in_data, out_data;
  modport master(output in_valid, in_data, out_ready, input in_ready, out_valid, out_data, out_last, busy);
  modport slave(input in_valid, in_data, out_ready, output in_ready, out_valid, out_data, out_last, busy);
endinterface

// File: rtl/ntt_seq.sv
// ntt_seq: serial-load, one-butterfly-per-clock in-place radix-2 DIT NTT over Z_Q
module ntt_seq #(
  parameter int          BITS = 32,
  parameter int          N    = 8,
  parameter int unsigned Q    = 17,
  parameter int unsigned W    = 2
) (
  input logic  clk,
  input logic  rst,
  ntt_if.slave bus
);
  localparam int LOGN = $clog2(N);
  localparam logic [BITS:0] Q1 = (BITS+1)'(Q);
  typedef enum logic [1:0] {LOAD, COMPUTE, UNLOAD} state_t;
  typedef logic [N-1:0][BITS-1:0] tw_t;
  function automatic tw_t tw_table();
    tw_t t;
    logic [2*BITS-1:0] p;
    p = 1;
    for (int i = 0; i < N; i++) begin
      t[i] = BITS'(p);
      p = (p * W) % Q;
    end
    return t;
  endfunction
  localparam tw_t TW = tw_table();
  function automatic logic [LOGN-1:0] bitrev(input logic [LOGN-1:0] v);
    logic [LOGN-1:0] r;
    for (int i = 0; i < LOGN; i++) r[i] = v[LOGN-1-i];
    return r;
  endfunction
  state_t          state_q, state_d;
  logic [LOGN-1:0] idx_q, idx_d, stage_q, stage_d;
  logic [BITS-1:0] a_q [N];
  logic [BITS-1:0] a_d [N];
  logic [LOGN-1:0] j, top, bot, tw_i;
  logic [2*BITS-1:0] prod;
  logic [BITS-1:0] at, ab, t;
  logic [BITS:0]   sum;
  // idx_q is the butterfly number in COMPUTE; the group/offset split depends on the stage
  always_comb begin
    j    = idx_q & ((LOGN'(1) << stage_q) - LOGN'(1));
    top  = ((idx_q >> stage_q) << (stage_q + 1)) | j;
    bot  = top | (LOGN'(1) << stage_q);
    tw_i = j << (LOGN - 1 - stage_q);
    at   = a_q[top];
    ab   = a_q[bot];
    prod = {{BITS{1'b0}}, TW[tw_i]} * {{BITS{1'b0}}, ab};
    t    = BITS'(prod % Q);
    sum  = {1'b0, at} + {1'b0, t};
  end
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    stage_d = stage_q;
    a_d     = a_q;
    case (state_q)
      LOAD: if (bus.in_valid) begin
        a_d[bitrev(idx_q)] = BITS'(bus.in_data % Q);
        idx_d = idx_q + LOGN'(1);
        state_d = idx_q == LOGN'(N-1) ? COMPUTE : LOAD;
      end
      COMPUTE: begin
        a_d[top] = BITS'(sum >= Q1 ? sum - Q1 : sum);
        a_d[bot] = at < t ? BITS'({1'b0, at} + Q1 - {1'b0, t}) : at - t;
        idx_d = idx_q + LOGN'(1);
        if (idx_q == LOGN'(N/2-1)) begin
          idx_d   = '0;
          stage_d = stage_q == LOGN'(LOGN-1) ? '0 : stage_q + LOGN'(1);
          state_d = stage_q == LOGN'(LOGN-1) ? UNLOAD : COMPUTE;
        end
      end
      UNLOAD: if (bus.out_ready) begin
        idx_d = idx_q + LOGN'(1);
        state_d = idx_q == LOGN'(N-1) ? LOAD : UNLOAD;
      end
      default: state_d = LOAD;
    endcase
  end
  always_ff @(posedge clk) begin
    a_q <= a_d;
    if (rst) begin
      state_q <= LOAD;
      idx_q   <= '0;
      stage_q <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      stage_q <= stage_d;
    end
  end
  assign bus.in_ready  = state_q == LOAD && !rst;
  assign bus.out_valid = state_q == UNLOAD;
  assign bus.out_data  = state_q == UNLOAD ? a_q[idx_q] : '0;
  assign bus.out_last  = state_q == UNLOAD && idx_q == LOGN'(N-1);
  assign bus.busy      = state_q == COMPUTE;
endmodule

// File: doc/ntt_seq.md
# ntt_seq

Sequential, parametrised N-point forward number-theoretic transform engine over Z_Q. It is the successor to the fixed 4-point combinational butterfly network. It accepts N coefficients serially and holds them in an internal register array. It then runs an in-place radix-2 decimation-in-time transform using one butterfly per clock, and streams the N results out serially in natural order. It sits between the polynomial coefficient source and the pointwise multiplier of the polynomial multiplier datapath.

## Interface
- BITS, 32: coefficient width; all data ports and stored words are BITS wide.
- N, 8: transform length; power of two, at least 2. LOGN = log2(N) is derived.
- Q, 17: modulus; 2 <= Q < 2^BITS.
- W, 2: primitive N-th root of unity mod Q (W^N = 1 and W^(N/2) = Q-1). The default is valid for N=8, Q=17.
- clk  in  1  single clock; all state changes on the rising edge.
- rst  in  1  reset, synchronous, active-high.
- in_valid  in  1  in_data carries a coefficient.
- in_ready  out  1  engine accepts a coefficient (high only in LOAD).
- in_data  in  BITS  input coefficient x[n], sent in natural order n = 0..N-1.
- out_valid  out  1  out_data carries a result.
- out_ready  in  1  downstream accepts the result.
- out_data  out  BITS  result X[k], sent in natural order k = 0..N-1.
- out_last  out  1  high with X[N-1].
- busy  out  1  high in COMPUTE.

## Operation
- The engine computes X[k] = sum over n of x[n]·W^(n·k) mod Q. Every X[k] lies in [0, Q-1].
- There are three states: LOAD, COMPUTE and UNLOAD. Reset puts the engine in LOAD and clears all counters.
- **LOAD**
  - in_ready = 1.
  - On each in_valid & in_ready, store (in_data mod Q) at address bitrev(n), then increment n.
  - On the N-th accept, go to COMPUTE.
- **COMPUTE**
  - Counters: stage s = 1..LOGN, group base k in steps of m = 2^s, and j = 0..m/2-1.
  - Each cycle performs one butterfly with h = m/2 and twiddle w = W^(j·N/m) mod Q:
    - t = (w·A[k+j+h]) mod Q, with the product formed at 2·BITS width.
    - A[k+j] = (A[k+j] + t) mod Q.
    - A[k+j+h] = (A[k+j] − t) mod Q, computed as A + Q − t when A < t.
  - Sums are formed at BITS+1 width so that no overflow occurs.
  - The twiddles W^i, i = 0..N/2-1, come from a constant table computed at elaboration.
  - After (N/2)·LOGN butterflies, go to UNLOAD.
- **UNLOAD**
  - out_data = A[k], with out_valid = 1.
  - k advances only on out_valid & out_ready. out_data and out_valid stay stable while out_ready = 0.
  - After the transfer with k = N-1, go to LOAD and zero all counters.
- Inputs are ignored outside LOAD. in_valid while in_ready = 0 has no effect.
- rst asserted in any state returns the engine to LOAD on the next edge, discards all data, and clears the counters. Array contents need not be cleared; they are fully overwritten on the next load.

## Timing
- **Outputs during and after reset:** in_ready = 0 while rst is high. After rst falls: in_ready = 1, out_valid = 0, out_last = 0, busy = 0, out_data = 0.
- **LOAD:** accepts one coefficient per cycle at full rate. Minimum duration is N cycles.
- **LOAD to COMPUTE:** in_ready drops and busy rises in the cycle after the N-th accept.
- **COMPUTE:** lasts exactly (N/2)·LOGN cycles; this is 12 cycles for N=8.
- **COMPUTE to UNLOAD:** out_valid rises in the first cycle after COMPUTE, while busy = 0.
- **UNLOAD:** delivers one result per cycle when out_ready is held high.
- **UNLOAD to LOAD:** in_ready = 1 in the cycle after the last output transfer.
- **Latency:** from the last input accept to X[0] valid is (N/2)·LOGN + 1 cycles.
- **Block throughput:** one block per 2N + (N/2)·LOGN cycles with no stalls.

## Test plan
All scenarios use N=8, Q=17, W=2.
- Impulse: x = [1,0,0,0,0,0,0,0] → X = [1,1,1,1,1,1,1,1], out_last only on the 8th output, busy high for exactly 12 cycles.
- Constant: x = [1,1,1,1,1,1,1,1] → X = [8,0,0,0,0,0,0,0].
- Shifted impulse: x[1] = 1, others 0 → X = [1,2,4,8,16,15,13,9]. This exercises every twiddle and the subtraction wrap.
- Backpressure and input gaps:
  - Random in_valid gaps and random out_ready, with x = [3,16,0,5,9,1,12,7].
  - Required: results match a reference model; out_data is held stable during stalls; values are never ≥ 17.
  - in_data = 20 loads as 3.
- Reset mid-operation:
  - Assert rst during COMPUTE, and separately on the 4th output.
  - Required: in_ready = 1 after release, then a fresh impulse block yields all ones.
- Back-to-back: two blocks, impulse then constant, with out_ready held high → the outputs are the correct sequences and in_ready returns exactly one cycle after the first block's out_last transfer.
